cr_cddip_sa_dump: RTL and testbench

Snapshot dump sequencer that sits directly downstream of the CDDIP stats aggregator and consumes its snapshot counter array. On a dump request it triggers an aggregator snapshot, waits for the snapshot to settle, then streams every counter out as a tagged 64-bit word over a valid/ready interface for telemetry/DMA. It optionally suppresses zero-valued counters and flags snapshots that change under it mid-dump.

---
 rtl/cr_cddip_sa_dump_if.sv | 21 ++
 rtl/cr_cddip_sa_dump.sv | 138 +++++++++++++
 tb/tb_cr_cddip_sa_dump.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cr_cddip_sa_dump_if.sv
// Valid/ready stream carrying tagged snapshot counter words out of the dump sequencer.
interface cr_cddip_sa_dump_if;
  logic        dump_valid;
  logic        dump_ready;
  logic [63:0] dump_data;
  logic        dump_last;

  modport master (
    output dump_valid,
    output dump_data,
    output dump_last,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_data,
    input  dump_last,
    output dump_ready
  );
endinterface

// File: rtl/cr_cddip_sa_dump.sv
// Snapshot dump sequencer: triggers an aggregator snapshot, waits for it to settle, then streams
// every counter as {module_id, idx, count} with optional zero suppression and collision flagging.
module cr_cddip_sa_dump #(
  parameter int unsigned N_CNT    = 64,
  parameter int unsigned CNT_W    = 50,
  parameter int unsigned SNAP_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   dump_req,
  input  logic                   dump_skip_zero,
  input  logic [7:0]             cddip_sa_module_id,
  input  logic [N_CNT*CNT_W-1:0] sa_snapshot,
  input  logic                   regs_sa_snap,
  output logic                   dump_snap,
  cr_cddip_sa_dump_if.master     dump,
  output logic                   dump_busy,
  output logic                   dump_done,
  output logic                   dump_collision
);

  localparam int unsigned IdxW      = 6;
  localparam int unsigned CntFieldW = 50;

  typedef enum logic [2:0] {StIdle, StSnap, StWait, StScan, StDone} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [2:0]          wait_q, wait_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic [63:0]         data_q, data_d;
  logic                snap_q, snap_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                coll_q, coll_d;

  logic [CNT_W-1:0]    cnt_arr [N_CNT];
  logic [CNT_W-1:0]    cnt_cur;
  logic                is_last;
  logic                skip;
  logic                can_eval;

  for (genvar g = 0; g < N_CNT; g++) begin : g_unpack
    assign cnt_arr[g] = sa_snapshot[g*CNT_W +: CNT_W];
  end

  assign cnt_cur = cnt_arr[idx_q];
  assign is_last = (idx_q == IdxW'(N_CNT - 1));
  assign skip    = dump_skip_zero && (cnt_cur == '0) && !is_last;
  // Stop evaluating once the last word is loaded; it is only drained from here on.
  assign can_eval = (state_q == StScan) && (!valid_q || dump.dump_ready) && !(valid_q && last_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      wait_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      snap_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
      snap_q  <= snap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      coll_q  <= coll_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (dump_req) state_d = StSnap;
      StSnap:  state_d = StWait;
      StWait:  if (wait_q == '0) state_d = StScan;
      StScan:  if (valid_q && last_q && dump.dump_ready) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    idx_d   = idx_q;
    wait_d  = wait_q;
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    coll_d  = coll_q;

    if (valid_q && dump.dump_ready) valid_d = 1'b0;

    if (can_eval) begin
      if (!skip) begin
        data_d  = {cddip_sa_module_id, idx_q, CntFieldW'(cnt_cur)};
        valid_d = 1'b1;
        last_d  = is_last;
      end
      if (!is_last) idx_d = idx_q + 1'b1;
    end

    if (state_q == StSnap) begin
      wait_d = 3'(SNAP_LAT - 1);
    end else if (state_q == StWait && wait_q != '0) begin
      wait_d = wait_q - 1'b1;
    end

    if ((state_q == StWait || state_q == StScan) && regs_sa_snap) coll_d = 1'b1;

    if (state_q == StIdle && dump_req) begin
      idx_d  = '0;
      last_d = 1'b0;
      coll_d = 1'b0;
    end

    snap_d = (state_d == StSnap);
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  assign dump.dump_valid = valid_q;
  assign dump.dump_data  = data_q;
  assign dump.dump_last  = last_q;
  assign dump_snap       = snap_q;
  assign dump_busy       = busy_q;
  assign dump_done       = done_q;
  assign dump_collision  = coll_q;

endmodule

// File: tb/tb_cr_cddip_sa_dump.sv
// Randomized bench for cr_cddip_sa_dump: a queue of expected words built from the snapshot array
// is compared against every handshake, plus latency, stall-stability and reset checks.
module tb_cr_cddip_sa_dump;

  localparam int unsigned N_CNT    = 64;
  localparam int unsigned CNT_W    = 50;
  localparam int unsigned SNAP_LAT = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   dump_req;
  logic                   dump_skip_zero;
  logic [7:0]             module_id;
  logic [N_CNT*CNT_W-1:0] sa_snapshot;
  logic                   regs_sa_snap;
  logic                   dump_snap;
  logic                   dump_busy;
  logic                   dump_done;
  logic                   dump_collision;
  logic [CNT_W-1:0]       snap [N_CNT];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  cr_cddip_sa_dump_if sif ();

  cr_cddip_sa_dump #(
    .N_CNT   (N_CNT),
    .CNT_W   (CNT_W),
    .SNAP_LAT(SNAP_LAT)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .dump_req          (dump_req),
    .dump_skip_zero    (dump_skip_zero),
    .cddip_sa_module_id(module_id),
    .sa_snapshot       (sa_snapshot),
    .regs_sa_snap      (regs_sa_snap),
    .dump_snap         (dump_snap),
    .dump              (sif.master),
    .dump_busy         (dump_busy),
    .dump_done         (dump_done),
    .dump_collision    (dump_collision)
  );

  for (genvar g = 0; g < N_CNT; g++) begin : g_pack
    assign sa_snapshot[g*CNT_W +: CNT_W] = snap[g];
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 = ready always high, 1 = ready one cycle in three, 2 = random ready
  task automatic run_dump(input bit skip, input int mode, input bit coll_pulse, input bit req_busy,
                          input bit chk_timing);
    logic [63:0] exp_q[$];
    logic [63:0] e;
    logic [63:0] pd;
    logic        pl, pv, pr, rdy;
    int          t0, first_v, last_x, done_c, n_x, n_exp;
    bit          seen_done, pulsed_c, pulsed_r;

    for (int i = 0; i < int'(N_CNT); i++) begin
      if (!(skip && snap[i] == '0 && i != int'(N_CNT) - 1))
        exp_q.push_back({module_id, 6'(i), snap[i]});
    end
    n_exp = exp_q.size();
    dump_skip_zero = skip;

    dump_req = 1'b1;
    t0 = cyc;
    tick();
    dump_req = 1'b0;
    check("busy_t1", dump_busy, 1);
    check("snap_t1", dump_snap, 1);
    check("coll_clear_on_req", dump_collision, 0);
    tick();
    check("snap_t2", dump_snap, 0);

    first_v = -1; last_x = 0; done_c = 0; n_x = 0;
    seen_done = 0; pulsed_c = 0; pulsed_r = 0;
    pv = 0; pr = 0; pd = '0; pl = 0;
    for (int n = 0; n < 800 && !seen_done; n++) begin
      regs_sa_snap = 1'b0;
      dump_req     = 1'b0;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (n % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      sif.dump_ready = rdy;
      if (pv && !pr) begin
        check("stall_valid", sif.dump_valid, 1);
        check("stall_data", sif.dump_data, pd);
        check("stall_last", sif.dump_last, pl);
      end
      if (sif.dump_valid && first_v < 0) first_v = cyc;
      if (sif.dump_valid && rdy) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("word", sif.dump_data, e);
          check("last_flag", sif.dump_last, exp_q.size() == 0);
        end
        n_x++;
        last_x = cyc;
      end
      if (dump_done) begin
        seen_done = 1;
        done_c    = cyc;
      end
      pv = sif.dump_valid; pr = rdy; pd = sif.dump_data; pl = sif.dump_last;
      if (coll_pulse && !pulsed_c && n_x >= 10) begin
        regs_sa_snap = 1'b1;
        pulsed_c     = 1;
      end
      if (req_busy && !pulsed_r && n_x >= 20) begin
        dump_req = 1'b1;
        pulsed_r = 1;
      end
      if (!seen_done) tick();
    end
    regs_sa_snap = 1'b0;
    dump_req     = 1'b0;

    check("done_seen", seen_done, 1);
    check("word_count", n_x, n_exp);
    check("done_after_last", done_c - last_x, 1);
    if (chk_timing) begin
      check("first_valid_lat", first_v - t0, 3 + SNAP_LAT);
      check("done_lat", done_c - t0, 3 + SNAP_LAT + N_CNT);
    end
    tick();
    check("busy_clear", dump_busy, 0);
    check("valid_clear", sif.dump_valid, 0);
    check("done_one_cycle", dump_done, 0);
    check("collision", dump_collision, coll_pulse);
    tick();
    check("no_restart", dump_snap, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, sif.dump_valid, 0);
    check({tag, "_data"}, sif.dump_data, 0);
    check({tag, "_last"}, sif.dump_last, 0);
    check({tag, "_busy"}, dump_busy, 0);
    check({tag, "_done"}, dump_done, 0);
    check({tag, "_coll"}, dump_collision, 0);
    check({tag, "_snap"}, dump_snap, 0);
  endtask

  initial begin
    bit found;
    rst_n          = 1'b0;
    dump_req       = 1'b0;
    dump_skip_zero = 1'b0;
    module_id      = 8'h00;
    regs_sa_snap   = 1'b0;
    sif.dump_ready = 1'b0;
    for (int i = 0; i < int'(N_CNT); i++) snap[i] = '0;
    repeat (3) tick();
    check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Full dump with known values
    for (int i = 0; i < int'(N_CNT); i++) snap[i] = CNT_W'(i * 1000);
    module_id = 8'h5A;
    run_dump(0, 0, 0, 0, 1);

    // Backpressure, ready one cycle in three
    run_dump(0, 1, 0, 0, 0);

    // Zero suppression: only idx 5, 40 and the forced final idx 63
    for (int i = 0; i < int'(N_CNT); i++) snap[i] = '0;
    snap[5]  = 50'd77;
    snap[40] = 50'h3_0000_0000_0001;
    run_dump(1, 0, 0, 0, 0);

    // Collision plus ignored request, then a clean dump clears the flag
    for (int i = 0; i < int'(N_CNT); i++) snap[i] = CNT_W'({$urandom(), $urandom()});
    module_id = 8'hC3;
    run_dump(0, 2, 1, 1, 0);
    run_dump(0, 0, 0, 0, 1);

    // Count field boundary
    snap[0] = {CNT_W{1'b1}};
    module_id = 8'h81;
    dump_skip_zero = 1'b0;
    sif.dump_ready = 1'b1;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (sif.dump_valid) found = 1;
      else tick();
    end
    check("bound_seen", found, 1);
    check("bound_count", 64'(sif.dump_data[49:0]), 64'({CNT_W{1'b1}}));
    check("bound_idx", 64'(sif.dump_data[55:50]), 0);
    check("bound_id", 64'(sif.dump_data[63:56]), 64'h81);
    repeat (80) tick();
    check("bound_idle", dump_busy, 0);

    // Reset asserted mid-scan at idx 20
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      if (sif.dump_valid && sif.dump_data[55:50] == 6'd20) found = 1;
      else tick();
    end
    check("reached_idx20", found, 1);
    rst_n = 1'b0;
    #2;
    check_all_zero("midreset");
    @(negedge clk) rst_n = 1'b1;
    tick();
    check_all_zero("post_reset");
    run_dump(0, 0, 0, 0, 1);

    // Randomized dumps with sparse zeros
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < int'(N_CNT); i++)
        snap[i] = ($urandom_range(0, 1) != 0) ? '0 : CNT_W'({$urandom(), $urandom()});
      module_id = 8'($urandom());
      run_dump(1'($urandom_range(0, 1)), 2, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
